// File: rtl/pixel_buffer_if.sv
// ============================================================================
// Module      : pixel_buffer_if
// Description : Pixel request/response port plus video scanout word port
//               of the 1bpp framebuffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pixel_buffer_if;
    logic [8:0]  x_b;
    logic [7:0]  y_b;
    logic        read_b;
    logic        write_b;
    logic        in_b;
    logic        out_b;
    logic        rdy_b;
    logic [12:0] vid_addr;
    logic        vid_req;
    logic [7:0]  vid_data;
    logic        vid_valid;

    modport master (
        output x_b, y_b, read_b, write_b, in_b, vid_addr, vid_req,
        input  out_b, rdy_b, vid_data, vid_valid
    );

    modport slave (
        input  x_b, y_b, read_b, write_b, in_b, vid_addr, vid_req,
        output out_b, rdy_b, vid_data, vid_valid
    );
endinterface

`default_nettype wire

// File: rtl/pixel_buffer.sv
// ============================================================================
// Module      : pixel_buffer
// Description : 1bpp 320x200 framebuffer, port A pixel read-modify-write,
//               port B read-only scanout. Optional macro PIXEL_CACHE_EN adds
//               a one-word cache in front of port A.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pixel_buffer #(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 200,
    parameter int WPL    = 40
) (
    input  wire logic     clk,
    input  wire logic     rst,
    pixel_buffer_if.slave bus
);
    localparam int          WORDS     = WPL * HEIGHT;
    localparam logic [12:0] C_WORDS   = 13'(WORDS);
    localparam logic [12:0] C_LAST    = 13'(WORDS - 1);
    localparam logic [8:0]  C_XLIM    = 9'(WIDTH);
    localparam logic [7:0]  C_YLIM    = 8'(HEIGHT);

    typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_RD, S_RDW, S_WR} state_t;

    logic [7:0] mem [0:WORDS-1];

    state_t      state_q, state_d;
    logic        rdy_q, rdy_d, out_q, out_d;
    logic [12:0] clr_q, clr_d, word_q, word_d;
    logic [2:0]  bit_q, bit_d;
    logic        din_q, din_d, wr_q, wr_d;
    logic [7:0]  a_rdata_q, w_merged;
    logic [7:0]  vid_data_q;
    logic        vid_valid_q;

    // Every request goes through the one-deep slot; IDLE services it a cycle later.
    logic        pend_q, pend_din_q, pend_wr_q;
    logic [8:0]  pend_x_q;
    logic [7:0]  pend_y_q;
    logic        w_req, w_take, w_full_next, w_oor, w_hit, w_cbit;
    logic [12:0] w_pword;

    assign w_req       = bus.read_b | bus.write_b;
    assign w_take      = (state_q == S_IDLE) && pend_q;
    assign w_full_next = w_req | (pend_q & ~w_take);
    assign w_oor       = (pend_x_q >= C_XLIM) || (pend_y_q >= C_YLIM);
    assign w_pword     = {pend_y_q, 5'b0} + {2'b0, pend_y_q, 3'b0} + {7'b0, pend_x_q[8:3]};

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q     <= 1'b0;
            pend_x_q   <= '0;
            pend_y_q   <= '0;
            pend_din_q <= 1'b0;
            pend_wr_q  <= 1'b0;
        end else if (w_req) begin
            pend_q     <= 1'b1;
            pend_x_q   <= bus.x_b;
            pend_y_q   <= bus.y_b;
            pend_din_q <= bus.in_b;
            pend_wr_q  <= bus.write_b;
        end else if (w_take) begin
            pend_q     <= 1'b0;
        end
    end

`ifdef PIXEL_CACHE_EN
    logic [12:0] tag_q;
    logic [7:0]  cdata_q;
    logic        cvalid_q;

    assign w_hit  = cvalid_q && (tag_q == w_pword) && !w_oor;
    assign w_cbit = cdata_q[pend_x_q[2:0]];

    always_ff @(posedge clk) begin
        if (rst || state_q == S_CLEAR) begin
            cvalid_q <= 1'b0;
            tag_q    <= '0;
            cdata_q  <= '0;
        end else if (state_q == S_RDW) begin
            cvalid_q <= 1'b1;
            tag_q    <= word_q;
            cdata_q  <= a_rdata_q;
        end else if (state_q == S_WR && cvalid_q && tag_q == word_q) begin
            cdata_q  <= w_merged;
        end
    end
`else
    assign w_hit  = 1'b0;
    assign w_cbit = 1'b0;
`endif

    always_comb begin
        w_merged         = a_rdata_q;
        w_merged[bit_q]  = din_q;
    end

    always_comb begin
        state_d = state_q;
        rdy_d   = rdy_q;
        out_d   = out_q;
        clr_d   = clr_q;
        word_d  = word_q;
        bit_d   = bit_q;
        din_d   = din_q;
        wr_d    = wr_q;
        case (state_q)
            S_CLEAR: begin
                rdy_d = 1'b0;
                clr_d = clr_q + 13'd1;
                if (clr_q == C_LAST) begin
                    state_d = S_IDLE;
                    rdy_d   = ~w_full_next;
                end
            end
            S_IDLE: begin
                if (w_req) rdy_d = 1'b0;
                if (pend_q) begin
                    word_d = w_pword;
                    bit_d  = pend_x_q[2:0];
                    din_d  = pend_din_q;
                    wr_d   = pend_wr_q;
                    if (w_oor) begin
                        if (!pend_wr_q) out_d = 1'b0;
                        rdy_d = ~w_full_next;
                    end else if (w_hit && !pend_wr_q) begin
                        out_d = w_cbit;
                        rdy_d = ~w_full_next;
                    end else if (w_hit) begin
                        state_d = S_WR;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD: state_d = S_RDW;
            S_RDW: begin
                if (wr_q) begin
                    state_d = S_WR;
                end else begin
                    out_d   = a_rdata_q[bit_q];
                    rdy_d   = ~w_full_next;
                    state_d = S_IDLE;
                end
            end
            S_WR: begin
                rdy_d   = ~w_full_next;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_CLEAR;
                clr_d   = '0;
                rdy_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_CLEAR;
            rdy_q   <= 1'b0;
            out_q   <= 1'b0;
            clr_q   <= '0;
            word_q  <= '0;
            bit_q   <= '0;
            din_q   <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rdy_q   <= rdy_d;
            out_q   <= out_d;
            clr_q   <= clr_d;
            word_q  <= word_d;
            bit_q   <= bit_d;
            din_q   <= din_d;
            wr_q    <= wr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == S_CLEAR)
                mem[clr_q] <= 8'h00;
            else if (state_q == S_WR)
                mem[word_q] <= w_merged;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == S_RD)
            a_rdata_q <= mem[word_q];
`ifdef PIXEL_CACHE_EN
        else if (w_take && w_hit)
            a_rdata_q <= cdata_q;
`endif
    end

    // Reads sample the array before any same-edge port A write lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            vid_valid_q <= 1'b0;
            vid_data_q  <= 8'h00;
        end else begin
            vid_valid_q <= bus.vid_req;
            if (bus.vid_req)
                vid_data_q <= (bus.vid_addr < C_WORDS) ? mem[bus.vid_addr] : 8'h00;
        end
    end

    assign bus.rdy_b     = rdy_q;
    assign bus.out_b     = out_q;
    assign bus.vid_data  = vid_data_q;
    assign bus.vid_valid = vid_valid_q;
endmodule

`default_nettype wire
